// File: rtl/stopwatch_timekeeper_pkg.sv
// Shared definitions for the stopwatch: FSM state encoding, BCD digit constants
// and the tick-divider length helper.
package stopwatch_timekeeper_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_SETTING = 2'd2
  } state_t;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

  function automatic int unsigned calc_ticks(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/stopwatch_timekeeper_bcd_decade.sv
// One BCD decade: counts 0..9 on inc, wraps to 0, and flags carry_out when an
// increment arrives at 9 so the next decade can be chained.
module bcd_decade
  import stopwatch_timekeeper_pkg::*;
(
  input  logic               clk,
  input  logic               inc,
  input  logic               load_zero,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry_out
);

  always_ff @(posedge clk) begin
    if (load_zero) begin
      digit <= '0;
    end else if (inc) begin
      // >= keeps the digit inside 0..9 even if it ever held an illegal code
      digit <= (digit >= MAX_DIGIT) ? '0 : digit + 4'd1;
    end
  end

  assign carry_out = inc && (digit == MAX_DIGIT);

endmodule

// File: rtl/stopwatch_timekeeper.sv
// Stopwatch core: tick divider, STOPPED/RUNNING/SETTING control FSM and a
// four-decade BCD counter presenting SS.hh on number.
module stopwatch_timekeeper
  import stopwatch_timekeeper_pkg::*;
#(
  parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int unsigned TICK_RATE_IN_HZ             = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        set_toggle,
  input  logic        digit_inc,
  output logic [15:0] number,
  output logic        set_mode,
  output logic        running,
  output logic [1:0]  set_digit
);

  localparam int unsigned TICKS = calc_ticks(BOARD_CLOCK_FREQUENCY_IN_HZ, TICK_RATE_IN_HZ);
  localparam int unsigned CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS - 1);

  state_t           state, state_n;
  logic [1:0]       set_digit_n;
  logic             set_inc;
  logic [CNT_W-1:0] div_cnt;
  logic             tick, tick_inc, load_zero;

  logic [DIGIT_W-1:0] d0, d1, d2, d3;
  logic inc0, inc1, inc2, inc3;
  logic carry0, carry1, carry2, carry3_unused;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_STOPPED;
      set_digit <= 2'd3;
    end else begin
      state     <= state_n;
      set_digit <= set_digit_n;
    end
  end

  // Pulses are resolved in priority order; the first applicable one wins.
  always_comb begin
    state_n     = state;
    set_digit_n = set_digit;
    set_inc     = 1'b0;
    if (clear) begin
      state_n = ST_STOPPED;
    end else begin
      unique case (state)
        ST_STOPPED: begin
          if (set_toggle) begin
            state_n     = ST_SETTING;
            set_digit_n = 2'd3;
          end else if (start_stop) begin
            state_n = ST_RUNNING;
          end
        end
        ST_RUNNING: begin
          if (start_stop) state_n = ST_STOPPED;
        end
        ST_SETTING: begin
          if (set_toggle) begin
            state_n = ST_STOPPED;
          end else if (start_stop) begin
            set_digit_n = set_digit - 2'd1;
          end else if (digit_inc) begin
            set_inc = 1'b1;
          end
        end
        default: state_n = ST_STOPPED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear || state != ST_RUNNING || div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick      = (state == ST_RUNNING) && (div_cnt == LAST);
  assign tick_inc  = tick && !clear;
  assign load_zero = rst || clear;

  // SETTING steers a single digit with no carry; otherwise the tick ripples up.
  always_comb begin
    if (state == ST_SETTING) begin
      inc0 = set_inc && (set_digit == 2'd0);
      inc1 = set_inc && (set_digit == 2'd1);
      inc2 = set_inc && (set_digit == 2'd2);
      inc3 = set_inc && (set_digit == 2'd3);
    end else begin
      inc0 = tick_inc;
      inc1 = carry0;
      inc2 = carry1;
      inc3 = carry2;
    end
  end

  bcd_decade u_hundredths (
    .clk(clk), .inc(inc0), .load_zero(load_zero), .digit(d0), .carry_out(carry0)
  );
  bcd_decade u_tenths (
    .clk(clk), .inc(inc1), .load_zero(load_zero), .digit(d1), .carry_out(carry1)
  );
  bcd_decade u_seconds (
    .clk(clk), .inc(inc2), .load_zero(load_zero), .digit(d2), .carry_out(carry2)
  );
  bcd_decade u_tens (
    .clk(clk), .inc(inc3), .load_zero(load_zero), .digit(d3), .carry_out(carry3_unused)
  );

  assign number   = {d3, d2, d1, d0};
  assign set_mode = (state == ST_SETTING);
  assign running  = (state == ST_RUNNING);

endmodule
